// File: rtl/pwm_pkg.sv
// Shared types and duty conversion helpers for the PID PWM output stage.
package pwm_pkg;

  typedef enum logic [1:0] {
    StLowOn,
    StDeadR,
    StHighOn,
    StDeadF
  } gate_state_e;

  // Clamp an integer duty request into [0, hi].
  function automatic longint clamp_duty(input longint v, input longint hi);
    if (v < 0) begin
      return 0;
    end else if (v > hi) begin
      return hi;
    end
    return v;
  endfunction

  function automatic logic duty_clamped(input longint v, input longint hi);
    return (v < 0) || (v > hi);
  endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Gate FSM: turns the raw PWM reference into complementary gate drives with a fixed dead time.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int unsigned DEAD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic fault_lat,
  output logic pwm_h,
  output logic pwm_l
);

  localparam int unsigned DtW = $clog2(DEAD + 1);
  localparam logic [DtW-1:0] DeadC = DtW'(DEAD);

  gate_state_e    state_q, state_d;
  logic [DtW-1:0] dt_q, dt_d;
  logic           pwm_h_d, pwm_l_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StLowOn;
      dt_q    <= '0;
      pwm_h   <= 1'b0;
      pwm_l   <= 1'b0;
    end else begin
      state_q <= state_d;
      dt_q    <= dt_d;
      pwm_h   <= pwm_h_d;
      pwm_l   <= pwm_l_d;
    end
  end

  // dt counts DEAD..1; the dead state is left in the cycle dt reads 1.
  always_comb begin
    state_d = state_q;
    dt_d    = dt_q;
    if (fault_lat) begin
      state_d = StDeadF;
      dt_d    = DeadC;
    end else begin
      case (state_q)
        StLowOn: begin
          if (raw) begin
            state_d = StDeadR;
            dt_d    = DeadC;
          end
        end
        StDeadR: begin
          if (!raw) begin
            state_d = StLowOn;
          end else if (dt_q <= DtW'(1)) begin
            state_d = StHighOn;
          end else begin
            dt_d = dt_q - DtW'(1);
          end
        end
        StHighOn: begin
          if (!raw) begin
            state_d = StDeadF;
            dt_d    = DeadC;
          end
        end
        StDeadF: begin
          if (raw) begin
            state_d = StHighOn;
          end else if (dt_q <= DtW'(1)) begin
            state_d = StLowOn;
          end else begin
            dt_d = dt_q - DtW'(1);
          end
        end
        default: state_d = StLowOn;
      endcase
    end
  end

  always_comb begin
    pwm_h_d = (state_d == StHighOn);
    pwm_l_d = (state_d == StLowOn);
  end

endmodule

// File: rtl/pid_pwm_out.sv
// Center-aligned PWM output stage for the PID controller, with shadowed duty and fault latch.
module pid_pwm_out
  import pwm_pkg::*;
#(
  parameter int unsigned W      = 32,
  parameter int unsigned FW     = 16,
  parameter int unsigned CW     = 12,
  parameter int unsigned PERIOD = 100,
  parameter int unsigned DEAD   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [W-1:0] din,
  input  logic                din_valid,
  input  logic                fault,
  input  logic                fault_clr,
  output logic                tick,
  output logic                pwm_h,
  output logic                pwm_l,
  output logic                sat,
  output logic                fault_lat,
  output logic [CW-1:0]       cnt
);

  localparam logic [CW-1:0] PeriodC = CW'(PERIOD);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic                dir_down_q, dir_down_d;
  logic                run_q;
  logic                tick_q;
  logic [CW-1:0]       shadow_q, duty_q;
  logic                shadow_sat_q, sat_q;
  logic                fault_lat_q, fault_lat_d;
  logic signed [W-1:0] din_int;
  logic [CW-1:0]       duty_new;
  logic                sat_new;
  logic                raw;

  assign din_int  = din >>> FW;
  assign duty_new = CW'(clamp_duty(longint'(din_int), longint'(PERIOD)));
  assign sat_new  = duty_clamped(longint'(din_int), longint'(PERIOD));

  // The first cycle after reset release is spent at cnt==0 so the first tick is not lost.
  always_comb begin
    cnt_d      = cnt_q;
    dir_down_d = dir_down_q;
    if (!run_q) begin
      cnt_d = '0;
    end else if (!dir_down_q) begin
      if (cnt_q == PeriodC) begin
        cnt_d      = PeriodC - CW'(1);
        dir_down_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        dir_down_d = 1'b0;
      end
    end
  end

  always_comb begin
    fault_lat_d = fault_lat_q;
    if (fault) begin
      fault_lat_d = 1'b1;
    end else if (fault_clr) begin
      fault_lat_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      dir_down_q   <= 1'b0;
      run_q        <= 1'b0;
      tick_q       <= 1'b0;
      shadow_q     <= '0;
      shadow_sat_q <= 1'b0;
      duty_q       <= '0;
      sat_q        <= 1'b0;
      fault_lat_q  <= 1'b0;
    end else begin
      run_q       <= 1'b1;
      cnt_q       <= cnt_d;
      dir_down_q  <= dir_down_d;
      tick_q      <= (cnt_d == '0);
      fault_lat_q <= fault_lat_d;
      if (din_valid) begin
        shadow_q     <= duty_new;
        shadow_sat_q <= sat_new;
      end
      // A request arriving in the tick cycle bypasses the shadow.
      if (tick_q) begin
        duty_q <= din_valid ? duty_new : shadow_q;
        sat_q  <= din_valid ? sat_new : shadow_sat_q;
      end
    end
  end

  assign raw = (duty_q == PeriodC) || (cnt_q < duty_q);

  // The gate FSM sees the next latch value so gates drop in the same cycle fault_lat rises.
  pwm_deadtime #(
    .DEAD(DEAD)
  ) u_deadtime (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw      (raw),
    .fault_lat(fault_lat_d),
    .pwm_h    (pwm_h),
    .pwm_l    (pwm_l)
  );

  assign tick      = tick_q;
  assign sat       = sat_q;
  assign fault_lat = fault_lat_q;
  assign cnt       = cnt_q;

endmodule

// File: tb/tb_pid_pwm_out.sv
// Directed bench for pid_pwm_out: period timing, duty loading, clamping, dead time, fault, reset.
module tb_pid_pwm_out;

  logic        clk;
  logic        rst_n;
  logic [31:0] din;
  logic        din_valid;
  logic        fault;
  logic        fault_clr;
  logic        tick;
  logic        pwm_h;
  logic        pwm_l;
  logic        sat;
  logic        fault_lat;
  logic [11:0] cnt;

  int n_cmp = 0;
  int n_err = 0;

  pid_pwm_out #(
    .W     (32),
    .FW    (16),
    .CW    (12),
    .PERIOD(100),
    .DEAD  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .din_valid(din_valid),
    .fault    (fault),
    .fault_clr(fault_clr),
    .tick     (tick),
    .pwm_h    (pwm_h),
    .pwm_l    (pwm_l),
    .sat      (sat),
    .fault_lat(fault_lat),
    .cnt      (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One 200-cycle window starting at a tick cycle; optional din strobe at cycle strobe_at.
  task automatic run_win(input string tag, input int strobe_at, input logic [31:0] sdin,
                         input int eh, input int el, input int ez);
    int nh, nl, nz, nb, nt;
    nh = 0; nl = 0; nz = 0; nb = 0; nt = 0;
    for (int i = 0; i < 200; i++) begin
      if (pwm_h) nh++;
      if (pwm_l) nl++;
      if (!pwm_h && !pwm_l) nz++;
      if (pwm_h && pwm_l) nb++;
      if (tick) nt++;
      if (i == strobe_at) begin
        din       = sdin;
        din_valid = 1'b1;
      end
      @(negedge clk);
      din_valid = 1'b0;
    end
    check_eq({tag, "_h"}, nh, eh);
    check_eq({tag, "_l"}, nl, el);
    check_eq({tag, "_dead"}, nz, ez);
    check_eq({tag, "_both"}, nb, 0);
    check_eq({tag, "_ticks"}, nt, 1);
    check_eq({tag, "_tick_end"}, int'(tick), 1);
  endtask

  task automatic wait_tick();
    int found;
    found = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tick) begin
        found = 1;
        break;
      end
    end
    check_eq("wait_tick", found, 1);
  endtask

  initial begin
    int gates;
    rst_n     = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    fault     = 1'b0;
    fault_clr = 1'b0;
    #2 rst_n = 1'b0;

    // Reset state and first tick one clock after release
    repeat (5) @(negedge clk);
    check_eq("rst_tick", int'(tick), 0);
    check_eq("rst_pwm_h", int'(pwm_h), 0);
    check_eq("rst_pwm_l", int'(pwm_l), 0);
    check_eq("rst_sat", int'(sat), 0);
    check_eq("rst_flat", int'(fault_lat), 0);
    check_eq("rst_cnt", int'(cnt), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("first_tick", int'(tick), 1);
    check_eq("first_cnt", int'(cnt), 0);
    check_eq("first_pwm_l", int'(pwm_l), 1);
    run_win("s1_idle", -1, 32'h0, 0, 200, 0);

    // 50.0 strobed after tick: deferred one period, then steady 95/97 with 4-clk gaps
    run_win("s2_defer", 1, 32'h0032_0000, 0, 200, 0);
    run_win("s2_first", -1, 32'h0, 89, 99, 12);
    run_win("s2_steady", -1, 32'h0, 95, 97, 8);
    check_eq("s2_sat", int'(sat), 0);

    // -3.5 clamps to 0, then 250.0 clamps to PERIOD
    run_win("s3_neg", 1, 32'hFFFC_8000, 95, 97, 8);
    run_win("s3_zero", 1, 32'h00FA_0000, 2, 194, 4);
    check_eq("s3_sat_neg", int'(sat), 1);
    run_win("s3_full", -1, 32'h0, 194, 2, 4);
    check_eq("s3_sat_full", int'(sat), 1);
    check_eq("s3_full_h", int'(pwm_h), 1);

    // Strobe in the tick cycle loads at once; one clock later waits a period
    run_win("s4_bypass", 0, 32'h0014_0000, 35, 157, 8);
    check_eq("s4_sat", int'(sat), 0);
    run_win("s4_defer", 1, 32'h000A_0000, 35, 157, 8);
    run_win("s4_next", -1, 32'h0, 15, 177, 8);

    // Fault during HIGH_ON, clear ignored while fault is high, recovery via DEAD_F
    check_eq("s5_pre_h", int'(pwm_h), 1);
    @(negedge clk);
    fault = 1'b1;
    @(negedge clk);
    check_eq("s5_flat", int'(fault_lat), 1);
    check_eq("s5_h_off", int'(pwm_h), 0);
    check_eq("s5_l_off", int'(pwm_l), 0);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    fault     = 1'b0;
    check_eq("s5_clr_ignored", int'(fault_lat), 1);
    @(negedge clk);
    check_eq("s5_latched", int'(fault_lat), 1);
    gates = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pwm_h || pwm_l) gates++;
    end
    check_eq("s5_gates_held", gates, 0);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check_eq("s5_cleared", int'(fault_lat), 0);
    @(negedge clk);
    @(negedge clk);
    check_eq("s5_l_dead", int'(pwm_l), 0);
    @(negedge clk);
    check_eq("s5_l_on", int'(pwm_l), 1);
    check_eq("s5_h_on", int'(pwm_h), 0);

    // Asynchronous reset mid-period with duty 50
    wait_tick();
    run_win("s6_defer", 1, 32'h0032_0000, 15, 177, 8);
    repeat (30) @(negedge clk);
    check_eq("s6_pre_h", int'(pwm_h), 1);
    check_eq("s6_pre_cnt", int'(cnt), 30);
    rst_n = 1'b0;
    #1;
    check_eq("s6_rst_h", int'(pwm_h), 0);
    check_eq("s6_rst_l", int'(pwm_l), 0);
    check_eq("s6_rst_cnt", int'(cnt), 0);
    check_eq("s6_rst_sat", int'(sat), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("s6_tick", int'(tick), 1);
    check_eq("s6_cnt", int'(cnt), 0);
    check_eq("s6_pwm_l", int'(pwm_l), 1);
    run_win("s6_restart", -1, 32'h0, 0, 200, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
